// File: rtl/res_station_pkg.sv
// Shared widths, opcode encodings and types for the reservation station.
// Every file in the slice takes its sizes from here; nothing is redefined locally.
package res_station_pkg;

  localparam int InstrIdWidth = 6;
  localparam int ImmWidth     = 32;
  localparam int AddrWidth    = 32;
  localparam int WordWidth    = 32;
  localparam int ROBIdxWidth  = 4;
  localparam int RsSize       = 16;
  localparam int RsIdxW       = 4;

  typedef enum logic [InstrIdWidth-1:0] {
    OP_NOP   = 6'd0,
    OP_LUI   = 6'd1,
    OP_AUIPC = 6'd2,
    OP_JAL   = 6'd3,
    OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,
    OP_BNE   = 6'd6,
    OP_BLT   = 6'd7,
    OP_LW    = 6'd11,
    OP_SW    = 6'd16,
    OP_ADDI  = 6'd19,
    OP_SLTI  = 6'd20,
    OP_ANDI  = 6'd25,
    OP_ADD   = 6'd28,
    OP_SUB   = 6'd29,
    OP_AND   = 6'd37
  } instr_id_e;

  typedef logic [WordWidth-1:0]    word_t;
  typedef logic [ImmWidth-1:0]     imm_t;
  typedef logic [AddrWidth-1:0]    addr_t;
  typedef logic [ROBIdxWidth-1:0]  rob_idx_t;
  typedef logic [InstrIdWidth-1:0] instr_id_t;

  typedef struct packed {
    logic  rdy;
    word_t val;
  } opnd_t;

  typedef struct packed {
    logic     en;
    rob_idx_t pos;
    word_t    res;
  } cdb_t;

  typedef struct packed {
    logic      busy;
    instr_id_t instr_id;
    imm_t      imm;
    addr_t     pc;
    rob_idx_t  rob_pos;
    word_t     vj;
    word_t     vk;
    rob_idx_t  qj;
    rob_idx_t  qk;
    logic      qj_rdy;
    logic      qk_rdy;
  } rs_entry_t;

  // Operand snoop shared by dispatch bypass and per-entry wakeup. The ALU
  // port is checked first so it wins if both ports carry the same tag.
  function automatic opnd_t snoop(input logic rdy, input word_t val,
                                  input rob_idx_t tag, input cdb_t ex,
                                  input cdb_t lsb);
    snoop.rdy = rdy;
    snoop.val = val;
    if (!rdy) begin
      if (ex.en && ex.pos == tag) begin
        snoop.rdy = 1'b1;
        snoop.val = ex.res;
      end else if (lsb.en && lsb.pos == tag) begin
        snoop.rdy = 1'b1;
        snoop.val = lsb.res;
      end
    end
  endfunction

endpackage

// File: rtl/res_station_if.sv
// Dispatch, CDB and issue signals of the reservation station.
// master = decoder/CDB/EX side, slave = the station itself.
interface res_station_if;
  import res_station_pkg::*;

  logic      rdy_in;
  logic      clear_in;

  logic      disp_en_in;
  instr_id_t disp_instr_id_in;
  imm_t      disp_imm_in;
  addr_t     disp_pc_in;
  rob_idx_t  disp_rob_pos_in;
  logic      disp_qj_rdy_in;
  logic      disp_qk_rdy_in;
  word_t     disp_vj_in;
  word_t     disp_vk_in;
  rob_idx_t  disp_qj_in;
  rob_idx_t  disp_qk_in;

  logic      cdb_ex_en_in;
  rob_idx_t  cdb_ex_pos_in;
  word_t     cdb_ex_res_in;
  logic      cdb_lsb_en_in;
  rob_idx_t  cdb_lsb_pos_in;
  word_t     cdb_lsb_res_in;

  logic      full_out;
  logic      ex_en_out;
  instr_id_t ex_instr_id_out;
  imm_t      ex_imm_out;
  word_t     ex_rs1_out;
  word_t     ex_rs2_out;
  addr_t     ex_pc_out;
  rob_idx_t  ex_rob_pos_out;

  modport master (
    output rdy_in, clear_in,
    output disp_en_in, disp_instr_id_in, disp_imm_in, disp_pc_in, disp_rob_pos_in,
    output disp_qj_rdy_in, disp_qk_rdy_in, disp_vj_in, disp_vk_in, disp_qj_in, disp_qk_in,
    output cdb_ex_en_in, cdb_ex_pos_in, cdb_ex_res_in,
    output cdb_lsb_en_in, cdb_lsb_pos_in, cdb_lsb_res_in,
    input  full_out, ex_en_out, ex_instr_id_out, ex_imm_out,
    input  ex_rs1_out, ex_rs2_out, ex_pc_out, ex_rob_pos_out
  );

  modport slave (
    input  rdy_in, clear_in,
    input  disp_en_in, disp_instr_id_in, disp_imm_in, disp_pc_in, disp_rob_pos_in,
    input  disp_qj_rdy_in, disp_qk_rdy_in, disp_vj_in, disp_vk_in, disp_qj_in, disp_qk_in,
    input  cdb_ex_en_in, cdb_ex_pos_in, cdb_ex_res_in,
    input  cdb_lsb_en_in, cdb_lsb_pos_in, cdb_lsb_res_in,
    output full_out, ex_en_out, ex_instr_id_out, ex_imm_out,
    output ex_rs1_out, ex_rs2_out, ex_pc_out, ex_rob_pos_out
  );

endinterface

// File: rtl/res_station_select.sv
// Lowest-index priority encoder: index of the first set request plus a found flag.
module rs_select #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scanning from the top lets the lowest set bit overwrite last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/res_station.sv
// Reservation station: holds dispatched ops, snoops both CDB ports for
// operands, and issues the lowest-index ready entry through registered outputs.
module res_station
  import res_station_pkg::*;
#(
  parameter int RS_SIZE  = RsSize,
  parameter int RS_IDX_W = RsIdxW
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  res_station_if.slave  bus
);

  rs_entry_t           ent_q [RS_SIZE];
  opnd_t               wake_j [RS_SIZE];
  opnd_t               wake_k [RS_SIZE];
  logic [RS_SIZE-1:0]  free_vec;
  logic [RS_SIZE-1:0]  elig_vec;
  logic [RS_IDX_W-1:0] free_idx;
  logic [RS_IDX_W-1:0] sel_idx;
  logic                free_found;
  logic                sel_found;
  cdb_t                cdb_ex;
  cdb_t                cdb_lsb;
  opnd_t               disp_j;
  opnd_t               disp_k;
  rs_entry_t           disp_ent;

  logic                ex_en_q;
  instr_id_t           ex_instr_id_q;
  imm_t                ex_imm_q;
  word_t               ex_rs1_q;
  word_t               ex_rs2_q;
  addr_t               ex_pc_q;
  rob_idx_t            ex_rob_pos_q;

  always_comb begin
    cdb_ex.en   = bus.cdb_ex_en_in;
    cdb_ex.pos  = bus.cdb_ex_pos_in;
    cdb_ex.res  = bus.cdb_ex_res_in;
    cdb_lsb.en  = bus.cdb_lsb_en_in;
    cdb_lsb.pos = bus.cdb_lsb_pos_in;
    cdb_lsb.res = bus.cdb_lsb_res_in;
  end

  // Eligibility comes from registered ready bits only, so a fresh dispatch
  // or a same-cycle wakeup cannot be selected before the next edge.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i] = !ent_q[i].busy;
      elig_vec[i] = ent_q[i].busy && ent_q[i].qj_rdy && ent_q[i].qk_rdy;
      wake_j[i]   = snoop(ent_q[i].qj_rdy, ent_q[i].vj, ent_q[i].qj, cdb_ex, cdb_lsb);
      wake_k[i]   = snoop(ent_q[i].qk_rdy, ent_q[i].vk, ent_q[i].qk, cdb_ex, cdb_lsb);
    end
  end

  rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_sel (
    .req   (free_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_issue_sel (
    .req   (elig_vec),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_comb begin
    disp_j            = snoop(bus.disp_qj_rdy_in, bus.disp_vj_in, bus.disp_qj_in, cdb_ex, cdb_lsb);
    disp_k            = snoop(bus.disp_qk_rdy_in, bus.disp_vk_in, bus.disp_qk_in, cdb_ex, cdb_lsb);
    disp_ent          = '0;
    disp_ent.busy     = 1'b1;
    disp_ent.instr_id = bus.disp_instr_id_in;
    disp_ent.imm      = bus.disp_imm_in;
    disp_ent.pc       = bus.disp_pc_in;
    disp_ent.rob_pos  = bus.disp_rob_pos_in;
    disp_ent.vj       = disp_j.val;
    disp_ent.vk       = disp_k.val;
    disp_ent.qj       = bus.disp_qj_in;
    disp_ent.qk       = bus.disp_qk_in;
    disp_ent.qj_rdy   = disp_j.rdy;
    disp_ent.qk_rdy   = disp_k.rdy;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      ex_en_q       <= 1'b0;
      ex_instr_id_q <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_pc_q       <= '0;
      ex_rob_pos_q  <= '0;
    end else if (bus.clear_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i].busy   <= 1'b0;
        ent_q[i].qj_rdy <= 1'b0;
        ent_q[i].qk_rdy <= 1'b0;
      end
      ex_en_q <= 1'b0;
    end else if (!bus.rdy_in) begin
      ex_en_q <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent_q[i].busy) begin
          ent_q[i].qj_rdy <= wake_j[i].rdy;
          ent_q[i].vj     <= wake_j[i].val;
          ent_q[i].qk_rdy <= wake_k[i].rdy;
          ent_q[i].vk     <= wake_k[i].val;
        end
      end
      ex_en_q <= sel_found;
      if (sel_found) begin
        ex_instr_id_q        <= ent_q[sel_idx].instr_id;
        ex_imm_q             <= ent_q[sel_idx].imm;
        ex_rs1_q             <= ent_q[sel_idx].vj;
        ex_rs2_q             <= ent_q[sel_idx].vk;
        ex_pc_q              <= ent_q[sel_idx].pc;
        ex_rob_pos_q         <= ent_q[sel_idx].rob_pos;
        ent_q[sel_idx].busy  <= 1'b0;
      end
      // The free search sees pre-edge busy bits, so a slot freed by this
      // issue can never be the dispatch target on the same edge.
      if (bus.disp_en_in && free_found) ent_q[free_idx] <= disp_ent;
    end
  end

  assign bus.full_out        = !free_found;
  assign bus.ex_en_out       = ex_en_q;
  assign bus.ex_instr_id_out = ex_instr_id_q;
  assign bus.ex_imm_out      = ex_imm_q;
  assign bus.ex_rs1_out      = ex_rs1_q;
  assign bus.ex_rs2_out      = ex_rs2_q;
  assign bus.ex_pc_out       = ex_pc_q;
  assign bus.ex_rob_pos_out  = ex_rob_pos_q;

endmodule

// File: tb/tb_res_station.sv
// Directed bench for res_station: hand-computed expectations, checked
// one cycle-step at a time.
module tb_res_station;
  import res_station_pkg::*;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic done     = 1'b0;

  res_station_if bus ();

  res_station #(.RS_SIZE(16), .RS_IDX_W(4)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.disp_en_in    = 1'b0;
    bus.cdb_ex_en_in  = 1'b0;
    bus.cdb_lsb_en_in = 1'b0;
  endtask

  task automatic disp(input instr_id_e op, input imm_t imm, input addr_t pc,
                      input rob_idx_t rob, input logic jr, input word_t vj,
                      input rob_idx_t qj, input logic kr, input word_t vk,
                      input rob_idx_t qk);
    bus.disp_en_in       = 1'b1;
    bus.disp_instr_id_in = op;
    bus.disp_imm_in      = imm;
    bus.disp_pc_in       = pc;
    bus.disp_rob_pos_in  = rob;
    bus.disp_qj_rdy_in   = jr;
    bus.disp_vj_in       = vj;
    bus.disp_qj_in       = qj;
    bus.disp_qk_rdy_in   = kr;
    bus.disp_vk_in       = vk;
    bus.disp_qk_in       = qk;
  endtask

  task automatic cdb_ex(input rob_idx_t pos, input word_t res);
    bus.cdb_ex_en_in  = 1'b1;
    bus.cdb_ex_pos_in = pos;
    bus.cdb_ex_res_in = res;
  endtask

  task automatic cdb_lsb(input rob_idx_t pos, input word_t res);
    bus.cdb_lsb_en_in  = 1'b1;
    bus.cdb_lsb_pos_in = pos;
    bus.cdb_lsb_res_in = res;
  endtask

  initial begin
    #100000;
    if (!done) begin
      failures++;
      $error("FAIL timeout: directed sequence did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    idle();
    disp(OP_NOP, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    bus.disp_en_in = 1'b0;
    bus.cdb_ex_pos_in = '0;  bus.cdb_ex_res_in = '0;
    bus.cdb_lsb_pos_in = '0; bus.cdb_lsb_res_in = '0;
    bus.clear_in = 1'b1;
    bus.rdy_in   = 1'b0;
    tick(); tick();
    chk("rst_full", bus.full_out, 1'b0);
    chk("rst_ex_en", bus.ex_en_out, 1'b0);
    chk("rst_rs1", bus.ex_rs1_out, 32'h0);
    chk("rst_rob", bus.ex_rob_pos_out, 4'd0);
    rst_n_in = 1'b1; bus.clear_in = 1'b0; bus.rdy_in = 1'b1;

    disp(OP_ADDI, 32'd3, 32'h100, 4'd2, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0);
    tick(); idle();
    chk("addi_early", bus.ex_en_out, 1'b0);
    tick();
    chk("addi_en", bus.ex_en_out, 1'b1);
    chk("addi_rs1", bus.ex_rs1_out, 32'd5);
    chk("addi_imm", bus.ex_imm_out, 32'd3);
    chk("addi_rob", bus.ex_rob_pos_out, 4'd2);
    chk("addi_pc", bus.ex_pc_out, 32'h100);
    chk("addi_op", bus.ex_instr_id_out, OP_ADDI);
    tick();
    chk("addi_one_shot", bus.ex_en_out, 1'b0);
    chk("addi_hold_rs1", bus.ex_rs1_out, 32'd5);

    disp(OP_ADD, 32'd0, 32'h104, 4'd3, 1'b0, 32'd0, 4'd7, 1'b1, 32'd1, 4'd0);
    tick(); idle(); tick(); tick();
    chk("add_wait", bus.ex_en_out, 1'b0);
    cdb_ex(4'd7, 32'h10);
    tick(); idle();
    chk("add_wake_early", bus.ex_en_out, 1'b0);
    tick();
    chk("add_en", bus.ex_en_out, 1'b1);
    chk("add_rs1", bus.ex_rs1_out, 32'h10);
    chk("add_rs2", bus.ex_rs2_out, 32'd1);
    chk("add_rob", bus.ex_rob_pos_out, 4'd3);
    tick();
    chk("add_one_shot", bus.ex_en_out, 1'b0);

    disp(OP_BEQ, 32'h8, 32'h108, 4'd5, 1'b0, 32'd0, 4'd4, 1'b1, 32'd2, 4'd0);
    cdb_lsb(4'd4, 32'd9);
    tick(); idle();
    chk("beq_early", bus.ex_en_out, 1'b0);
    tick();
    chk("beq_en", bus.ex_en_out, 1'b1);
    chk("beq_rs1", bus.ex_rs1_out, 32'd9);
    chk("beq_rs2", bus.ex_rs2_out, 32'd2);
    chk("beq_op", bus.ex_instr_id_out, OP_BEQ);
    tick();

    disp(OP_ADD, 32'd0, 32'h10c, 4'd6, 1'b0, 32'd0, 4'd5, 1'b1, 32'd3, 4'd0);
    cdb_ex(4'd5, 32'hA);
    cdb_lsb(4'd5, 32'hB);
    tick(); idle(); tick();
    chk("dual_en", bus.ex_en_out, 1'b1);
    chk("dual_rs1", bus.ex_rs1_out, 32'hA);
    tick();

    for (int i = 0; i < 15; i++) begin
      disp(OP_ADD, 32'd0, 32'(i * 4), 4'(i), 1'b0, 32'd0, 4'(i), 1'b1, 32'd0, 4'd0);
      tick();
    end
    idle();
    chk("fill_15_not_full", bus.full_out, 1'b0);
    disp(OP_ADD, 32'd0, 32'h3c, 4'd15, 1'b0, 32'd0, 4'd15, 1'b1, 32'd0, 4'd0);
    tick(); idle();
    chk("fill_16_full", bus.full_out, 1'b1);
    disp(OP_ADDI, 32'd7, 32'h200, 4'd15, 1'b1, 32'h77, 4'd0, 1'b1, 32'd0, 4'd0);
    tick(); idle(); tick();
    chk("full_drop_en", bus.ex_en_out, 1'b0);
    chk("full_still", bus.full_out, 1'b1);
    cdb_ex(4'd0, 32'h55);
    tick(); idle();
    chk("rel0_early", bus.ex_en_out, 1'b0);
    chk("rel0_full_hold", bus.full_out, 1'b1);
    tick();
    chk("rel0_en", bus.ex_en_out, 1'b1);
    chk("rel0_rs1", bus.ex_rs1_out, 32'h55);
    chk("rel0_rob", bus.ex_rob_pos_out, 4'd0);
    chk("rel0_full_fall", bus.full_out, 1'b0);
    bus.clear_in = 1'b1;
    tick(); bus.clear_in = 1'b0;
    chk("clr_full", bus.full_out, 1'b0);
    chk("clr_en", bus.ex_en_out, 1'b0);

    for (int i = 0; i < 4; i++) begin
      disp(OP_ADD, 32'd0, 32'd0, 4'(8 + i), 1'b0, 32'd0, 4'(8 + i), 1'b1, 32'd0, 4'd0);
      tick();
    end
    disp(OP_ADDI, 32'd1, 32'd0, 4'd12, 1'b1, 32'h12, 4'd0, 1'b1, 32'd0, 4'd0);
    tick();
    bus.clear_in = 1'b1;
    disp(OP_ADDI, 32'd2, 32'd0, 4'd13, 1'b1, 32'h13, 4'd0, 1'b1, 32'd0, 4'd0);
    tick(); bus.clear_in = 1'b0; idle();
    chk("flush_full", bus.full_out, 1'b0);
    chk("flush_en", bus.ex_en_out, 1'b0);
    cdb_ex(4'd8, 32'd1);
    cdb_lsb(4'd9, 32'd2);
    tick(); idle();
    chk("flush_quiet1", bus.ex_en_out, 1'b0);
    tick();
    chk("flush_quiet2", bus.ex_en_out, 1'b0);
    tick();
    chk("flush_quiet3", bus.ex_en_out, 1'b0);
    chk("flush_rob_hold", bus.ex_rob_pos_out, 4'd0);

    for (int i = 0; i < 10; i++) begin
      disp(OP_ADD, 32'd0, 32'd0, 4'(i), 1'b0, 32'd0, 4'(i), 1'b1, 32'd0, 4'd0);
      tick();
    end
    idle();
    cdb_ex(4'd3, 32'h33);
    cdb_lsb(4'd9, 32'h90);
    tick(); idle();
    bus.rdy_in = 1'b0;
    cdb_ex(4'd1, 32'h44);
    disp(OP_ADDI, 32'd0, 32'd0, 4'd14, 1'b1, 32'hEE, 4'd0, 1'b1, 32'd0, 4'd0);
    tick(); idle();
    chk("stall_1", bus.ex_en_out, 1'b0);
    tick();
    chk("stall_2", bus.ex_en_out, 1'b0);
    tick();
    chk("stall_3", bus.ex_en_out, 1'b0);
    tick();
    chk("stall_4", bus.ex_en_out, 1'b0);
    bus.rdy_in = 1'b1;
    tick();
    chk("resume_a_en", bus.ex_en_out, 1'b1);
    chk("resume_a_rob", bus.ex_rob_pos_out, 4'd3);
    chk("resume_a_rs1", bus.ex_rs1_out, 32'h33);
    tick();
    chk("resume_b_en", bus.ex_en_out, 1'b1);
    chk("resume_b_rob", bus.ex_rob_pos_out, 4'd9);
    chk("resume_b_rs1", bus.ex_rs1_out, 32'h90);
    tick();
    chk("resume_none", bus.ex_en_out, 1'b0);

    rst_n_in = 1'b0; bus.clear_in = 1'b1;
    tick();
    rst_n_in = 1'b1; bus.clear_in = 1'b0;
    chk("mid_rst_full", bus.full_out, 1'b0);
    chk("mid_rst_en", bus.ex_en_out, 1'b0);
    chk("mid_rst_rs1", bus.ex_rs1_out, 32'h0);
    chk("mid_rst_rob", bus.ex_rob_pos_out, 4'd0);
    disp(OP_ADDI, 32'h21, 32'h300, 4'd11, 1'b1, 32'd7, 4'd0, 1'b1, 32'd8, 4'd0);
    tick(); idle(); tick();
    chk("post_rst_en", bus.ex_en_out, 1'b1);
    chk("post_rst_rs1", bus.ex_rs1_out, 32'd7);
    chk("post_rst_rs2", bus.ex_rs2_out, 32'd8);
    chk("post_rst_imm", bus.ex_imm_out, 32'h21);
    chk("post_rst_pc", bus.ex_pc_out, 32'h300);
    chk("post_rst_rob", bus.ex_rob_pos_out, 4'd11);
    tick();
    chk("post_rst_none", bus.ex_en_out, 1'b0);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
